// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle, word-addressed data memory serving MEM-stage
// load/store requests over a req/ack handshake with a fixed access latency.
// stall_o freezes the pipeline while a request is outstanding.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned accesses flag err_o,
// suppress the store and return zero for loads).
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        stall_o,
    output logic        err_o
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [1:0]  ST_IDLE  = 2'd0;
    localparam logic [1:0]  ST_BUSY  = 2'd1;
    localparam logic [1:0]  ST_RESP  = 2'd2;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    // A byte address is misaligned when it does not point at a word boundary.
    function automatic logic misaligned(input logic [1:0] byte_off);
        return (byte_off != 2'b00);
    endfunction

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] idx_q, idx_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          mis_q, mis_d;
    logic          ack_q, ack_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem_q [DEPTH_WORDS];

    logic [AW-1:0] idx_in_s;
    logic          mis_in_s;
    logic [AW-1:0] acc_idx_s;
    logic          acc_we_s;
    logic          acc_mis_s;
    logic          enter_resp_s;
    logic          mem_we_s;
    logic          unused_addr_s;

    // Upper address bits wrap; the byte offset matters only with the alignment check.
    assign idx_in_s      = addr_i[AW+1:2];
    assign unused_addr_s = ^{addr_i[31:AW+2], addr_i[1:0]};

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_in_s = misaligned(addr_i[1:0]);
`else
    assign mis_in_s = 1'b0;
`endif

    // Control FSM: accept in IDLE, count down in BUSY, answer in RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        mis_d   = mis_q;
        case (state_q)
            ST_IDLE: begin
                if (req_i) begin
                    we_d    = we_i;
                    idx_d   = idx_in_s;
                    wdata_d = wdata_i;
                    mis_d   = mis_in_s;
                    cnt_d   = CNT_INIT;
                    if (CNT_INIT == 4'd0) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_BUSY;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (!req_i) begin
                    // Requester withdrew: abandon without writing or acking.
                    state_d = ST_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                // The response always completes, regardless of req_i.
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Response path: with LATENCY=1 RESP is entered straight from IDLE, so the
    // live request fields are used; otherwise the latched ones.
    always_comb begin
        if (state_q == ST_IDLE) begin
            acc_idx_s = idx_in_s;
            acc_we_s  = we_i;
            acc_mis_s = mis_in_s;
        end else begin
            acc_idx_s = idx_q;
            acc_we_s  = we_q;
            acc_mis_s = mis_q;
        end
        enter_resp_s = (state_d == ST_RESP);
        ack_d        = enter_resp_s;
        err_d        = enter_resp_s & acc_mis_s;
        if (enter_resp_s && !acc_we_s) begin
            if (acc_mis_s) begin
                rdata_d = 32'h0000_0000;
            end else begin
                rdata_d = mem_q[acc_idx_s];
            end
        end else begin
            rdata_d = rdata_q;
        end
        // A store commits on the edge leaving RESP unless reset lands on that edge.
        mem_we_s = (state_q == ST_RESP) & we_q & ~mis_q & ~rst_i;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            idx_q   <= '0;
            wdata_q <= 32'h0000_0000;
            mis_q   <= 1'b0;
            ack_q   <= 1'b0;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            mis_q   <= mis_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage array; contents survive reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            mem_q[idx_q] <= wdata_q;
        end
    end

    assign ack_o   = ack_q;
    assign rdata_o = rdata_q;
    assign err_o   = err_q;
    assign stall_o = req_i & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one DUT at LATENCY=3 with a
// behavioural memory model and random traffic, one at LATENCY=1.
module tb_dmem_responder;

    localparam int LAT_A  = 3;
    localparam int LAT_B  = 1;
    localparam int DEPTH  = 256;
    localparam int BUDGET = 20;
`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, we_a, ack_a, stall_a, err_a;
    logic [31:0] addr_a, wdata_a, rdata_a;
    logic        req_b, we_b, ack_b, stall_b, err_b;
    logic [31:0] addr_b, wdata_b, rdata_b;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] model_rdata;
    logic [31:0] pre_b;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req_a), .we_i(we_a), .addr_i(addr_a),
        .wdata_i(wdata_a), .ack_o(ack_a), .rdata_o(rdata_a), .stall_o(stall_a), .err_o(err_a)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req_b), .we_i(we_b), .addr_i(addr_b),
        .wdata_i(wdata_b), .ack_o(ack_b), .rdata_o(rdata_b), .stall_o(stall_b), .err_o(err_b)
    );

    always #5 clk = ~clk;

    // Reference model: word index wraps modulo depth; misalignment only matters when checked.
    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    function automatic bit is_mis(input logic [31:0] a);
        return ALIGN_EN && ((a % 32'd4) != 32'd0);
    endfunction

    function automatic void model_access(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                                         output logic [31:0] exp_rd, output logic exp_err);
        int i;
        i       = widx(addr);
        exp_err = is_mis(addr);
        if (we) begin
            if (!exp_err) model_mem[i] = wdata;
        end else begin
            model_rdata = exp_err ? 32'h0 : model_mem[i];
        end
        exp_rd = model_rdata;
    endfunction

    task automatic drive(input int sel, input bit r, input bit we, input logic [31:0] addr, input logic [31:0] wd);
        if (sel == 0) begin
            req_a = r; we_a = we; addr_a = addr; wdata_a = wd;
        end else begin
            req_b = r; we_b = we; addr_b = addr; wdata_b = wd;
        end
    endtask

    task automatic release_req(input int sel);
        @(negedge clk);
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // Issue one request starting in the next cycle and observe until ack (bounded).
    task automatic access(input int sel, input bit we, input logic [31:0] addr, input logic [31:0] wd,
                          output int ack_cyc, output int stall_cyc, output bit stall_at_ack,
                          output logic [31:0] rd, output logic er);
        logic a, s;
        ack_cyc = -1; stall_cyc = 0; stall_at_ack = 1'b1; rd = 32'h0; er = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, we, addr, wd);
        for (int c = 0; c < BUDGET; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            a = (sel == 0) ? ack_a : ack_b;
            s = (sel == 0) ? stall_a : stall_b;
            if (a === 1'b1) begin
                ack_cyc      = c;
                stall_at_ack = s;
                rd           = (sel == 0) ? rdata_a : rdata_b;
                er           = (sel == 0) ? err_a : err_b;
                break;
            end
            if (s === 1'b1) stall_cyc++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (ack_a !== 1'b0) begin n_bad++; $display("FAIL reset_ack: got %b expected 0", ack_a); end
        n_cmp++; if (rdata_a !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h expected 0", rdata_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b expected 0", err_a); end
        n_cmp++; if (stall_a !== 1'b0) begin n_bad++; $display("FAIL reset_stall_idle: got %b expected 0", stall_a); end
        n_cmp++; if (ack_b !== 1'b0 || rdata_b !== 32'h0) begin n_bad++; $display("FAIL reset_b: got ack %b rdata %h expected 0/0", ack_b, rdata_b); end
        req_a = 1'b1;
        #1;
        n_cmp++; if (stall_a !== 1'b1) begin n_bad++; $display("FAIL reset_stall_req: got %b expected 1", stall_a); end
        @(negedge clk);
        req_a = 1'b0;
        rst   = 1'b0;
        model_rdata = 32'h0;
    endtask

    task automatic preload();
        int ac, sc; bit sa; logic [31:0] rd, er_rd; logic er;
        for (int i = 0; i < DEPTH; i++) begin
            logic [31:0] d;
            d = $urandom;
            access(0, 1'b1, 32'(i * 4), d, ac, sc, sa, rd, er);
            model_access(1'b1, 32'(i * 4), d, er_rd, er);
        end
        release_req(0);
        pre_b = $urandom;
        access(1, 1'b1, 32'h0, pre_b, ac, sc, sa, rd, er);
        release_req(1);
    endtask

    task automatic test_store_load();
        int ac, sc; bit sa; logic [31:0] rd, exp_rd; logic er, exp_er;
        access(0, 1'b1, 32'h10, 32'hDEADBEEF, ac, sc, sa, rd, er);
        model_access(1'b1, 32'h10, 32'hDEADBEEF, exp_rd, exp_er);
        n_cmp++; if (ac !== LAT_A) begin n_bad++; $display("FAIL sl_store_ack_cycle: got %0d expected %0d", ac, LAT_A); end
        n_cmp++; if (sc !== LAT_A || sa !== 1'b0) begin n_bad++; $display("FAIL sl_store_stall: got %0d cycles/at_ack %b expected %0d/0", sc, sa, LAT_A); end
        n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL sl_store_err: got %b expected 0", er); end
        access(0, 1'b0, 32'h10, 32'h0, ac, sc, sa, rd, er);
        model_access(1'b0, 32'h10, 32'h0, exp_rd, exp_er);
        n_cmp++; if (ac !== LAT_A) begin n_bad++; $display("FAIL sl_load_ack_cycle: got %0d expected %0d", ac, LAT_A); end
        n_cmp++; if (sc !== LAT_A || sa !== 1'b0) begin n_bad++; $display("FAIL sl_load_stall: got %0d cycles/at_ack %b expected %0d/0", sc, sa, LAT_A); end
        n_cmp++; if (rd !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sl_load_data: got %h expected deadbeef", rd); end
        release_req(0);
    endtask

    task automatic test_latency1();
        int ac, sc; bit sa; logic [31:0] rd; logic er;
        access(1, 1'b0, 32'h0, 32'h0, ac, sc, sa, rd, er);
        n_cmp++; if (ac !== LAT_B) begin n_bad++; $display("FAIL l1_ack_cycle: got %0d expected %0d", ac, LAT_B); end
        n_cmp++; if (sc !== 1 || sa !== 1'b0) begin n_bad++; $display("FAIL l1_stall: got %0d cycles/at_ack %b expected 1/0", sc, sa); end
        n_cmp++; if (rd !== pre_b) begin n_bad++; $display("FAIL l1_rdata: got %h expected %h", rd, pre_b); end
        release_req(1);
    endtask

    task automatic test_abort();
        int acks, ac, sc; bit sa; logic [31:0] rd, old, exp_rd; logic er, exp_er;
        old  = model_mem[widx(32'h20)];
        acks = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h20, 32'h12345678);
        #1; if (ack_a === 1'b1) acks++;
        @(negedge clk);
        #1; if (ack_a === 1'b1) acks++;
        drive(0, 1'b0, 1'b1, 32'h20, 32'h12345678);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1; if (ack_a === 1'b1) acks++;
        end
        n_cmp++; if (acks !== 0) begin n_bad++; $display("FAIL abort_no_ack: got %0d acks expected 0", acks); end
        access(0, 1'b0, 32'h20, 32'h0, ac, sc, sa, rd, er);
        model_access(1'b0, 32'h20, 32'h0, exp_rd, exp_er);
        n_cmp++; if (ac !== LAT_A) begin n_bad++; $display("FAIL abort_reload_ack: got %0d expected %0d", ac, LAT_A); end
        n_cmp++; if (rd !== old) begin n_bad++; $display("FAIL abort_old_data: got %h expected %h", rd, old); end
        release_req(0);
    endtask

    task automatic test_wrap();
        int ac, sc; bit sa; logic [31:0] rd, exp_rd; logic er, exp_er;
        access(0, 1'b1, 32'h400, 32'hA5A5A5A5, ac, sc, sa, rd, er);
        model_access(1'b1, 32'h400, 32'hA5A5A5A5, exp_rd, exp_er);
        access(0, 1'b0, 32'h0, 32'h0, ac, sc, sa, rd, er);
        model_access(1'b0, 32'h0, 32'h0, exp_rd, exp_er);
        n_cmp++; if (rd !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL wrap_data: got %h expected a5a5a5a5", rd); end
        release_req(0);
    endtask

    task automatic test_misalign();
        int ac, sc; bit sa; logic [31:0] rd, d, old4, exp_w4, exp_rd; logic er, exp_er;
        old4   = model_mem[4];
        d      = $urandom;
        exp_w4 = ALIGN_EN ? old4 : d;
        access(0, 1'b1, 32'h13, d, ac, sc, sa, rd, er);
        model_access(1'b1, 32'h13, d, exp_rd, exp_er);
        n_cmp++; if (ac !== LAT_A) begin n_bad++; $display("FAIL mis_store_ack: got %0d expected %0d", ac, LAT_A); end
        n_cmp++; if (er !== ALIGN_EN) begin n_bad++; $display("FAIL mis_store_err: got %b expected %b", er, ALIGN_EN); end
        access(0, 1'b0, 32'h10, 32'h0, ac, sc, sa, rd, er);
        model_access(1'b0, 32'h10, 32'h0, exp_rd, exp_er);
        n_cmp++; if (rd !== exp_w4 || er !== 1'b0) begin n_bad++; $display("FAIL mis_word4: got %h err %b expected %h err 0", rd, er, exp_w4); end
        access(0, 1'b0, 32'h11, 32'h0, ac, sc, sa, rd, er);
        model_access(1'b0, 32'h11, 32'h0, exp_rd, exp_er);
        n_cmp++; if (rd !== exp_rd || er !== exp_er) begin n_bad++; $display("FAIL mis_load: got %h err %b expected %h err %b", rd, er, exp_rd, exp_er); end
        release_req(0);
    endtask

    task automatic test_reset_in_resp();
        int seen, ac, sc; bit sa; logic [31:0] rd, prior, exp_rd; logic er, exp_er;
        prior = model_mem[widx(32'h8)];
        seen  = 0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h8, 32'hFFFFFFFF);
        for (int c = 0; c < BUDGET; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (ack_a === 1'b1) begin seen = 1; break; end
        end
        n_cmp++; if (seen !== 1) begin n_bad++; $display("FAIL rr_ack_seen: got %0d expected 1", seen); end
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (ack_a !== 1'b0 || rdata_a !== 32'h0) begin n_bad++; $display("FAIL rr_after_reset: got ack %b rdata %h expected 0/0", ack_a, rdata_a); end
        rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        model_rdata = 32'h0;
        access(0, 1'b0, 32'h8, 32'h0, ac, sc, sa, rd, er);
        model_access(1'b0, 32'h8, 32'h0, exp_rd, exp_er);
        n_cmp++; if (rd !== prior) begin n_bad++; $display("FAIL rr_prior_data: got %h expected %h", rd, prior); end
        release_req(0);
    endtask

    task automatic test_back_to_back();
        int ac, sc; bit sa, we; logic [31:0] rd, addr, d, exp_rd; logic er, exp_er;
        for (int n = 0; n < 80; n++) begin
            we   = 1'($urandom_range(0, 1));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            d    = $urandom;
            access(0, we, addr, d, ac, sc, sa, rd, er);
            model_access(we, addr, d, exp_rd, exp_er);
            n_cmp++; if (ac !== LAT_A || sc !== LAT_A || sa !== 1'b0) begin n_bad++; $display("FAIL rnd_timing[%0d]: got ack %0d stall %0d/%b expected %0d/%0d/0", n, ac, sc, sa, LAT_A, LAT_A); end
            n_cmp++; if (rd !== exp_rd || er !== exp_er) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h err %b expected %h err %b (we %b addr %h)", n, rd, er, exp_rd, exp_er, we, addr); end
            if ($urandom_range(0, 1) == 0) release_req(0);
        end
        release_req(0);
    endtask

    initial begin
        test_reset();
        preload();
        test_store_load();
        test_latency1();
        test_abort();
        test_wrap();
        test_misalign();
        test_reset_in_resp();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
